jk_mod_counter: RTL
===================

Name: jk_mod_counter

Overview:
Synchronous modulo-N up/down counter built as a bank of JK flip-flops. Per-bit J/K excitation is derived from the desired next state. It is the next stage downstream of the single JK flip-flop cell: it consumes the JK cell's next-state law, Q+ = J&~Q | ~K&Q, replicated per bit. It feeds lab display/decoder stages through Q and cascades to further counters through Carry.

Parameters:
WIDTH, 4, counter bit width.
MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH; elaboration error otherwise.

Ports:
Clock  input  1  rising-edge clock.
Resetn  input  1  synchronous active-low reset.
En  input  1  count enable.
Load  input  1  synchronous parallel load.
Up  input  1  direction: 1 = up, 0 = down.
D  input  WIDTH  load value.
Q  output  WIDTH  counter state (registered).
QN  output  WIDTH  ~Q (combinational).
TC  output  1  terminal count (combinational).
Carry  output  1  registered one-cycle wrap pulse.

Behaviour:
- One clock: Clock. Reset is synchronous and active-low: Resetn = 0 sampled at posedge Clock gives Q = 0 and Carry = 0. No asynchronous path.
- Priority at each posedge: Resetn low > Load > En > hold.
- Load = 1: next state N = D if D < MODULUS, else MODULUS-1 (clamp). Load ignores En and Up. Carry = 0.
- En = 1, Load = 0, Up = 1: N = Q+1, or 0 if Q == MODULUS-1.
- En = 1, Load = 0, Up = 0: N = Q-1, or MODULUS-1 if Q == 0.
- En = 0: N = Q, with J = K = 0 on every bit.
- Excitation, mandatory structure, per bit i:
  - J[i] = ~Q[i] & N[i]
  - K[i] = Q[i] & ~N[i]
  - Q[i] <= J[i]&~Q[i] | ~K[i]&Q[i]
  - The J = K = 1 toggle case never occurs by construction.
- TC = (Up & Q == MODULUS-1) | (~Up & Q == 0). It is not gated by En; it follows Up combinationally.
- Carry <= 1 for exactly the cycle after a wrap edge, defined as Resetn & ~Load & En & TC. Otherwise Carry <= 0.
- Latency: Q updates one clock after the controlling inputs are sampled. Carry is coincident with the wrapped Q value.
- Direction change mid-count: takes effect at the next edge. No extra state.
- Reset mid-count: Q = 0 and Carry = 0 at that edge, whatever Load and En are.
- Q >= MODULUS is unreachable. No recovery logic is required beyond reset.
- Arithmetic is WIDTH bits. The MODULUS-1 compare is sized to WIDTH, with no truncation when MODULUS = 2^WIDTH.

Optional Feature:
JKCNT_SATURATE_EN
- Defined: the counter saturates instead of wrapping. With En & TC & ~Load, N = Q (hold), and Carry still pulses one cycle as an overflow/underflow flag. Up from MODULUS-1 holds at MODULUS-1; down from 0 holds at 0.
- Undefined: wrap behaviour exactly as above.

Test Plan:
- Reset: Resetn = 0 for 2 cycles with En = 1, Load = 1, D = 5 -> Q = 0, QN = 4'b1111, Carry = 0.
- Up wrap: En = 1, Up = 1 for 12 clocks from 0 -> Q runs 1..9, 0, 1, 2. Carry = 1 only in the cycle Q becomes 0. TC = 1 while Q = 9.
- Down wrap: Up = 0 from Q = 1, 3 clocks -> Q = 0, 9, 8. Carry = 1 only when Q becomes 9. TC = 1 while Q = 0.
- Load and clamp: Load = 1, D = 7 -> Q = 7. Load = 1, D = 12 -> Q = 9. Load = 1 with En = 1 at Q = 9 -> Carry stays 0.
- Hold/reset priority: En = 0 for 5 clocks at Q = 4 -> Q = 4. Resetn = 0 while counting at Q = 6 -> Q = 0 next edge.
- JKCNT_SATURATE_EN defined: up at Q = 9 for 3 clocks -> Q stays 9, Carry = 1 each cycle. Down at Q = 0 -> Q stays 0.

Source files
------------

// File: rtl/jk_mod_counter.sv
// jk_mod_counter
// --------------
// Synchronous modulo-MODULUS up/down counter built from a bank of JK
// flip-flops. The desired next state N is computed first, then each bit
// gets its own J/K excitation (J = ~Q & N, K = Q & ~N) and updates with
// the JK next-state law Q+ = J&~Q | ~K&Q.
//
// Parameters:
//   WIDTH    counter bit width
//   MODULUS  count range 0..MODULUS-1, legal range 2..2^WIDTH
//
// Ports:
//   Clock   rising-edge clock
//   Resetn  synchronous active-low reset (Q = 0, Carry = 0)
//   En      count enable
//   Load    synchronous parallel load, clamped to MODULUS-1
//   Up      direction: 1 = up, 0 = down
//   D       load value
//   Q       registered counter state
//   QN      ~Q (combinational)
//   TC      terminal count for the current direction (combinational)
//   Carry   registered one-cycle pulse on a wrap (or saturation) edge
//
// Optional build macro:
//   JKCNT_SATURATE_EN  when defined, the counter holds at its terminal
//                      value instead of wrapping; Carry still pulses.

module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Load,
    input  logic             Up,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             TC,
    output logic             Carry
);

    // Reject illegal moduli at elaboration time.
    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must lie in 2..2^WIDTH");
        end
    endgenerate

    // Top count value sized to WIDTH; MODULUS = 2^WIDTH gives all ones,
    // so nothing is lost by truncation.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j_bits;
    logic [WIDTH-1:0] k_bits;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (Q == MAX_VAL);
    assign at_zero = (Q == '0);
    assign TC      = Up ? at_max : at_zero;
    assign QN      = ~Q;

    // Next-state selection: Load beats En, En = 0 keeps N = Q so that
    // every J and K is zero and the flip-flops simply hold.
    always_comb begin
        next_q = Q;
        if (Load) begin
            next_q = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (En) begin
`ifdef JKCNT_SATURATE_EN
            if (TC) begin
                next_q = Q;
            end else if (Up) begin
                next_q = Q + WIDTH'(1);
            end else begin
                next_q = Q - WIDTH'(1);
            end
`else
            if (Up) begin
                next_q = at_max ? '0 : (Q + WIDTH'(1));
            end else begin
                next_q = at_zero ? MAX_VAL : (Q - WIDTH'(1));
            end
`endif
        end
    end

    // Per-bit excitation; J and K are never both set because a bit can
    // only be asked to rise (Q=0,N=1) or fall (Q=1,N=0), not both.
    assign j_bits = ~Q & next_q;
    assign k_bits = Q & ~next_q;

    // JK bank plus the registered wrap pulse. Reset has top priority.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            Q     <= '0;
            Carry <= 1'b0;
        end else begin
            Q     <= (j_bits & ~Q) | (~k_bits & Q);
            Carry <= ~Load & En & TC;
        end
    end

endmodule
